// File: rtl/rs_issue_scheduler.sv
// Oldest-first (or lowest-index) two-port issue picker for the ALU reservation station.
// Build option: define RS_AGE_ORDER_EN to pick by age matrix; otherwise lowest index wins.
module rs_issue_scheduler #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [1:0]         alloc_valid,
    input  logic [IDX_W-1:0]   alloc_idx0,
    input  logic [IDX_W-1:0]   alloc_idx1,
    input  logic [1:0]         alloc_fu,
    input  logic [ENTRIES-1:0] entry_ready,
    input  logic [1:0]         fu_rdy,
    output logic [1:0]         issue_valid,
    output logic [IDX_W-1:0]   issue_idx0,
    output logic [IDX_W-1:0]   issue_idx1,
    input  logic [1:0]         issue_ready,
    output logic [1:0]         release_valid,
    output logic [IDX_W:0]     occupancy
);

    logic [ENTRIES-1:0]      live_q, live_d, fu_q, fu_d;
    logic [ENTRIES-1:0]      held, busy, issued;
    logic [1:0][ENTRIES-1:0] cand, pick;
    logic [1:0][IDX_W-1:0]   pick_idx;
    logic [1:0]              load;

    // Handshake: port k transfers when issue_valid[k] && issue_ready[k]; a valid port keeps
    // issue_idx stable until that happens, and only then may a new grant be loaded.
    assign release_valid = issue_valid & issue_ready & {2{~flush}};

    always_comb begin
        held = '0;
        busy = live_q;
        if (issue_valid[0]) held[issue_idx0] = 1'b1;
        if (issue_valid[1]) held[issue_idx1] = 1'b1;
        if (issue_valid[0] && !issue_ready[0]) busy[issue_idx0] = 1'b1;
        if (issue_valid[1] && !issue_ready[1]) busy[issue_idx1] = 1'b1;
    end

    always_comb begin
        cand[0] = live_q & entry_ready & ~held & ~fu_q;
        cand[1] = live_q & entry_ready & ~held & fu_q;
    end

`ifdef RS_AGE_ORDER_EN
    // older_q[i][j] set means entry j was allocated before entry i.
    logic [ENTRIES-1:0] older_q [ENTRIES];
    logic [ENTRIES-1:0] older_d [ENTRIES];

    always_comb begin
        pick = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pick[k][i] = cand[k][i] && ((older_q[i] & cand[k]) == '0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) older_d[i] = older_q[i];
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) older_d[i] = '0;
        end else begin
            if (alloc_valid[0]) begin
                for (int i = 0; i < ENTRIES; i++) older_d[i][alloc_idx0] = 1'b0;
                older_d[alloc_idx0]             = live_q & ~issued;
                older_d[alloc_idx0][alloc_idx0] = 1'b0;
            end
            if (alloc_valid[1]) begin
                for (int i = 0; i < ENTRIES; i++) older_d[i][alloc_idx1] = 1'b0;
                older_d[alloc_idx1] = live_q & ~issued;
                if (alloc_valid[0]) older_d[alloc_idx1][alloc_idx0] = 1'b1;
                older_d[alloc_idx1][alloc_idx1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) older_q[i] <= older_d[i];
        end
    end
`else
    // Isolate the lowest set bit of each candidate vector.
    always_comb begin
        pick[0] = cand[0] & (~cand[0] + ENTRIES'(1));
        pick[1] = cand[1] & (~cand[1] + ENTRIES'(1));
    end
`endif

    always_comb begin
        pick_idx = '0;
        issued   = '0;
        load     = '0;
        for (int k = 0; k < 2; k++) begin
            load[k] = (!issue_valid[k] || issue_ready[k]) && fu_rdy[k] && (cand[k] != '0);
            for (int i = 0; i < ENTRIES; i++) begin
                if (pick[k][i]) pick_idx[k] = IDX_W'(i);
            end
            if (load[k]) issued = issued | pick[k];
        end
    end

    // Allocation is applied after the issue clear so a (illegal) reuse of a live slot wins.
    always_comb begin
        live_d = live_q & ~issued;
        fu_d   = fu_q;
        if (alloc_valid[0]) begin
            live_d[alloc_idx0] = 1'b1;
            fu_d[alloc_idx0]   = alloc_fu[0];
        end
        if (alloc_valid[1]) begin
            live_d[alloc_idx1] = 1'b1;
            fu_d[alloc_idx1]   = alloc_fu[1];
        end
        if (flush) live_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q      <= '0;
            fu_q        <= '0;
            issue_valid <= '0;
            issue_idx0  <= '0;
            issue_idx1  <= '0;
        end else begin
            live_q <= live_d;
            fu_q   <= fu_d;
            if (flush) begin
                issue_valid <= '0;
            end else begin
                if (load[0]) begin
                    issue_valid[0] <= 1'b1;
                    issue_idx0     <= pick_idx[0];
                end else if (issue_ready[0]) begin
                    issue_valid[0] <= 1'b0;
                end
                if (load[1]) begin
                    issue_valid[1] <= 1'b1;
                    issue_idx1     <= pick_idx[1];
                end else if (issue_ready[1]) begin
                    issue_valid[1] <= 1'b0;
                end
            end
        end
    end

    // Held entries still own their RS slot until the handshake frees it.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < ENTRIES; i++) occupancy = occupancy + (IDX_W+1)'(live_q[i]);
        occupancy = occupancy + (IDX_W+1)'(issue_valid[0]) + (IDX_W+1)'(issue_valid[1]);
    end

    always_ff @(posedge clk) begin
        if (reset_n && !flush) begin
            if (alloc_valid[0])
                assert (!busy[alloc_idx0]) else $error("allocate to occupied slot %0d", alloc_idx0);
            if (alloc_valid[1])
                assert (!busy[alloc_idx1]) else $error("allocate to occupied slot %0d", alloc_idx1);
            if (alloc_valid == 2'b11)
                assert (alloc_idx0 != alloc_idx1) else $error("both dispatch slots name slot %0d", alloc_idx0);
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed vector table, in-order scoreboard run, async reset.
module tb_rs_issue_scheduler;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;

`ifdef RS_AGE_ORDER_EN
    localparam logic [IDX_W-1:0] FIRST  = 3'd5;
    localparam logic [IDX_W-1:0] SECOND = 3'd2;
`else
    localparam logic [IDX_W-1:0] FIRST  = 3'd2;
    localparam logic [IDX_W-1:0] SECOND = 3'd5;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               flush;
    logic [1:0]         alloc_valid;
    logic [IDX_W-1:0]   alloc_idx0, alloc_idx1;
    logic [1:0]         alloc_fu;
    logic [ENTRIES-1:0] entry_ready;
    logic [1:0]         fu_rdy;
    logic [1:0]         issue_valid;
    logic [IDX_W-1:0]   issue_idx0, issue_idx1;
    logic [1:0]         issue_ready;
    logic [1:0]         release_valid;
    logic [IDX_W:0]     occupancy;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [IDX_W-1:0] exp_q0[$];
    logic [IDX_W-1:0] exp_q1[$];

    typedef struct {
        logic               flush;
        logic [1:0]         av;
        logic [IDX_W-1:0]   i0, i1;
        logic [1:0]         fu;
        logic [ENTRIES-1:0] er;
        logic [1:0]         fr, ir;
        logic [1:0]         e_iv;
        logic [IDX_W-1:0]   e_i0, e_i1;
        logic [1:0]         e_rel;
        logic [IDX_W:0]     e_occ;
    } vec_t;

    vec_t tbl[$];

    rs_issue_scheduler #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1),
        .alloc_fu(alloc_fu), .entry_ready(entry_ready), .fu_rdy(fu_rdy),
        .issue_valid(issue_valid), .issue_idx0(issue_idx0), .issue_idx1(issue_idx1),
        .issue_ready(issue_ready), .release_valid(release_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0; alloc_valid = 2'b00; alloc_idx0 = '0; alloc_idx1 = '0; alloc_fu = 2'b00;
        entry_ready = '1; fu_rdy = 2'b11; issue_ready = 2'b11;
    endtask

    task automatic add(input logic fl, input logic [1:0] av, input int i0, input int i1,
                       input logic [1:0] fu, input logic [7:0] er, input logic [1:0] fr,
                       input logic [1:0] ir, input logic [1:0] e_iv, input int e_i0,
                       input int e_i1, input logic [1:0] e_rel, input int e_occ);
        vec_t v;
        v.flush = fl; v.av = av; v.i0 = IDX_W'(i0); v.i1 = IDX_W'(i1); v.fu = fu; v.er = er;
        v.fr = fr; v.ir = ir; v.e_iv = e_iv; v.e_i0 = IDX_W'(e_i0); v.e_i1 = IDX_W'(e_i1);
        v.e_rel = e_rel; v.e_occ = (IDX_W+1)'(e_occ);
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset issue_valid", issue_valid, 0);
        check("reset issue_idx0", issue_idx0, 0);
        check("reset issue_idx1", issue_idx1, 0);
        check("reset release_valid", release_valid, 0);
        check("reset occupancy", occupancy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // flush av  i0 i1 fu     er     fr     ir     e_iv   e_i0  e_i1 e_rel  occ
        // dual issue
        add(0, 2'b11, 1, 3, 2'b10, 8'hff, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 0);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 2);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b11, 1,      3, 2'b11, 2);
        // age order: slot 5 then slot 2, ready only after both are allocated
        add(0, 2'b01, 5, 0, 2'b00, 8'h00, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 0);
        add(0, 2'b01, 2, 0, 2'b00, 8'h00, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 1);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 2);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b01, FIRST,  0, 2'b01, 2);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b01, SECOND, 0, 2'b01, 1);
        // stall on port 0 with two more FU0 entries waiting
        add(0, 2'b11, 0, 4, 2'b00, 8'hff, 2'b11, 2'b00, 2'b00, 0,      0, 2'b00, 0);
        add(0, 2'b01, 6, 0, 2'b00, 8'hff, 2'b11, 2'b00, 2'b00, 0,      0, 2'b00, 2);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b00, 2'b01, 0,      0, 2'b00, 3);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b00, 2'b01, 0,      0, 2'b00, 3);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b00, 2'b01, 0,      0, 2'b00, 3);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b01, 2'b01, 0,      0, 2'b01, 3);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b01, 2'b01, 4,      0, 2'b01, 2);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b01, 2'b01, 6,      0, 2'b01, 1);
        // fu_rdy gate on FU1
        add(0, 2'b10, 0, 7, 2'b10, 8'hff, 2'b01, 2'b11, 2'b00, 0,      0, 2'b00, 0);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b01, 2'b11, 2'b00, 0,      0, 2'b00, 1);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b01, 2'b11, 2'b00, 0,      0, 2'b00, 1);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 1);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b10, 0,      7, 2'b10, 1);
        // flush with six entries tracked and port 1 held
        add(0, 2'b11, 0, 1, 2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 0,      0, 2'b00, 0);
        add(0, 2'b11, 2, 3, 2'b00, 8'h00, 2'b11, 2'b00, 2'b00, 0,      0, 2'b00, 2);
        add(0, 2'b11, 4, 5, 2'b10, 8'h20, 2'b11, 2'b00, 2'b00, 0,      0, 2'b00, 4);
        add(0, 2'b00, 0, 0, 2'b00, 8'h20, 2'b11, 2'b00, 2'b00, 0,      0, 2'b00, 6);
        add(0, 2'b00, 0, 0, 2'b00, 8'h20, 2'b11, 2'b00, 2'b10, 0,      5, 2'b00, 6);
        add(1, 2'b01, 6, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b10, 0,      5, 2'b00, 6);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 0);
        add(0, 2'b00, 0, 0, 2'b00, 8'hff, 2'b11, 2'b11, 2'b00, 0,      0, 2'b00, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            flush = tbl[r].flush; alloc_valid = tbl[r].av; alloc_idx0 = tbl[r].i0;
            alloc_idx1 = tbl[r].i1; alloc_fu = tbl[r].fu; entry_ready = tbl[r].er;
            fu_rdy = tbl[r].fr; issue_ready = tbl[r].ir;
            @(negedge clk);
            check($sformatf("row%0d issue_valid", r), issue_valid, tbl[r].e_iv);
            if (tbl[r].e_iv[0]) check($sformatf("row%0d issue_idx0", r), issue_idx0, tbl[r].e_i0);
            if (tbl[r].e_iv[1]) check($sformatf("row%0d issue_idx1", r), issue_idx1, tbl[r].e_i1);
            check($sformatf("row%0d release_valid", r), release_valid, tbl[r].e_rel);
            check($sformatf("row%0d occupancy", r), occupancy, tbl[r].e_occ);
            tick();
        end

        // Scoreboard run: one allocate per cycle in ascending slot order, so age and index agree.
        idle_inputs();
        for (int round = 0; round < 3; round++) begin
            int slot = 0;
            int cyc  = 0;
            while ((slot < ENTRIES || exp_q0.size() + exp_q1.size() != 0) && cyc < 300) begin
                alloc_valid = 2'b00;
                if (slot < ENTRIES) begin
                    alloc_valid = 2'b01;
                    alloc_idx0  = IDX_W'(slot);
                    alloc_fu    = {1'b0, 1'($urandom_range(0, 1))};
                    if (alloc_fu[0]) exp_q1.push_back(IDX_W'(slot));
                    else             exp_q0.push_back(IDX_W'(slot));
                    slot++;
                end
                issue_ready = 2'($urandom_range(0, 3));
                fu_rdy      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                @(negedge clk);
                if (release_valid[0]) begin
                    if (exp_q0.size() == 0) begin
                        tests_run++; fail_cnt++;
                        $display("FAIL sb port0 release: got idx %0d expected no release", issue_idx0);
                    end else check("sb port0 idx", issue_idx0, exp_q0.pop_front());
                end
                if (release_valid[1]) begin
                    if (exp_q1.size() == 0) begin
                        tests_run++; fail_cnt++;
                        $display("FAIL sb port1 release: got idx %0d expected no release", issue_idx1);
                    end else check("sb port1 idx", issue_idx1, exp_q1.pop_front());
                end
                tick();
                cyc++;
            end
            alloc_valid = 2'b00;
            check($sformatf("sb round%0d pending", round), exp_q0.size() + exp_q1.size(), 0);
            @(negedge clk);
            check($sformatf("sb round%0d occupancy", round), occupancy, 0);
            tick();
        end

        // Asynchronous reset while a grant is held on port 0.
        idle_inputs();
        issue_ready = 2'b00;
        alloc_valid = 2'b11; alloc_idx0 = 3'd3; alloc_idx1 = 3'd4; alloc_fu = 2'b00;
        tick();
        alloc_valid = 2'b00;
        tick();
        @(negedge clk);
        check("pre-reset issue_valid", issue_valid, 2'b01);
        check("pre-reset occupancy", occupancy, 2);
        reset_n = 1'b0;
        #1;
        check("async reset issue_valid", issue_valid, 0);
        check("async reset occupancy", occupancy, 0);
        check("async reset release_valid", release_valid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
